// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card ROM loader: FSM encoding, sector size
// and the iNES header magic.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        RECV     = 3'd3,
        SEC_END  = 3'd4,
        FINISH   = 3'd5,
        ERR      = 3'd6
    } loader_state_t;

    localparam int SD_SECTOR_BYTES = 512;

    localparam logic [7:0] INES_MAGIC_0 = 8'h4E;
    localparam logic [7:0] INES_MAGIC_1 = 8'h45;
    localparam logic [7:0] INES_MAGIC_2 = 8'h53;
    localparam logic [7:0] INES_MAGIC_3 = 8'h1A;

    // Expected header byte for file offsets 0..3 ("NES",0x1A).
    function automatic logic [7:0] ines_magic(input logic [1:0] idx);
        case (idx)
            2'd0:    return INES_MAGIC_0;
            2'd1:    return INES_MAGIC_1;
            2'd2:    return INES_MAGIC_2;
            default: return INES_MAGIC_3;
        endcase
    endfunction

endpackage

// File: rtl/sd_byte_strobe.sv
// Rising-edge detector on the controller byte strobe; the data byte is
// registered alongside so it stays paired with its one-cycle pulse.
module sd_byte_strobe (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       byte_available,
    input  logic [7:0] din,
    output logic       byte_pulse,
    output logic [7:0] byte_data
);

    logic avail_q;

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            avail_q    <= 1'b0;
            byte_pulse <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            avail_q    <= byte_available;
            byte_pulse <= byte_available & ~avail_q;
            byte_data  <= din;
        end
    end

endmodule

// File: rtl/sd_rom_loader.sv
// Streams num_sectors consecutive SD sectors into a byte-wide memory port,
// checking the iNES magic and flagging controller timeouts and overflow.
module sd_rom_loader
    import sd_pkg::*;
#(
    parameter int MEM_AW       = 19,
    parameter int SECTOR_BYTES = SD_SECTOR_BYTES,
    parameter int TIMEOUT_CYC  = 2500000
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       num_sectors,
    input  logic              sd_ready,
    input  logic              sd_byte_available,
    input  logic [7:0]        sd_dout,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              header_ok,
    output logic [MEM_AW:0]   bytes_loaded
);

    localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   SEC_LAST   = 16'(SECTOR_BYTES - 1);
    localparam logic [31:0]   SEC_STRIDE = 32'(SECTOR_BYTES);
    localparam logic [MEM_AW:0] ONE_BYTE = {{MEM_AW{1'b0}}, 1'b1};

    loader_state_t state, state_next;

    logic [31:0] base_lat;
    logic [15:0] num_lat;
    logic [15:0] sector_idx;
    logic [15:0] sec_count;
    logic [31:0] tcount;
    logic        hdr_good;
    logic        byte_pulse;
    logic [7:0]  byte_data;

    logic        full;
    logic        byte_evt;
    logic        timeout_hit;
    logic        sector_last;
    logic [15:0] sector_next;
    logic        hdr_match;

    sd_byte_strobe u_strobe (
        .clk_25mhz      (clk_25mhz),
        .rst            (rst),
        .byte_available (sd_byte_available),
        .din            (sd_dout),
        .byte_pulse     (byte_pulse),
        .byte_data      (byte_data)
    );

    assign full        = bytes_loaded[MEM_AW];
    assign byte_evt    = byte_pulse && (state == RECV);
    assign timeout_hit = (tcount == TO_LAST);
    assign sector_last = (sec_count == SEC_LAST);
    assign sector_next = sector_idx + 16'd1;
    assign hdr_match   = (byte_data == ines_magic(bytes_loaded[1:0]));

    assign sd_rd = (state == ISSUE);
    assign busy  = (state != IDLE);
    assign done  = (state == FINISH) && !error;

    always_ff @(posedge clk_25mhz) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A byte pulse in RECV takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (num_sectors == 16'd0) ? FINISH : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (sd_ready)         state_next = ISSUE;
                else if (timeout_hit) state_next = ERR;
            end
            ISSUE: begin
                if (!sd_ready)        state_next = RECV;
                else if (timeout_hit) state_next = ERR;
            end
            RECV: begin
                if (byte_pulse) begin
                    if (full)             state_next = ERR;
                    else if (sector_last) state_next = SEC_END;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            SEC_END: state_next = (sector_next == num_lat) ? FINISH : WAIT_RDY;
            FINISH:  state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            base_lat     <= '0;
            num_lat      <= '0;
            sector_idx   <= '0;
            sec_count    <= '0;
            tcount       <= '0;
            hdr_good     <= 1'b0;
            sd_address   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            error        <= 1'b0;
            header_ok    <= 1'b0;
            bytes_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            tcount <= ((state_next != state) || byte_evt) ? 32'd0 : tcount + 32'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_lat     <= base_addr;
                        num_lat      <= num_sectors;
                        error        <= 1'b0;
                        header_ok    <= 1'b0;
                        hdr_good     <= 1'b1;
                        bytes_loaded <= '0;
                        sector_idx   <= '0;
                        sec_count    <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (sd_ready) sd_address <= base_lat + (32'(sector_idx) * SEC_STRIDE);
                end
                RECV: begin
                    if (byte_pulse && !full) begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= byte_data;
                        mem_addr     <= bytes_loaded[MEM_AW-1:0];
                        bytes_loaded <= bytes_loaded + ONE_BYTE;
                        sec_count    <= sector_last ? 16'd0 : sec_count + 16'd1;
                        // Header flag resolves together with the write of file byte 3.
                        if (bytes_loaded[MEM_AW:2] == '0) begin
                            if (bytes_loaded[1:0] == 2'd3) header_ok <= hdr_good & hdr_match;
                            else                           hdr_good  <= hdr_good & hdr_match;
                        end
                    end
                end
                SEC_END: sector_idx <= sector_next;
                ERR:     error      <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_rom_loader.sv
// Self-checking bench for sd_rom_loader: a behavioural sd_controller feeds
// bytes and pushes expected writes to a scoreboard popped on every mem_we.
`timescale 1ns/1ps
module tb_sd_rom_loader;

    localparam int TO_CYC = 1000;
    localparam int SB     = 512;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } sb_item_t;

    logic        clk_25mhz = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_sectors;
    logic        sd_ready;
    logic        sd_byte_available;
    logic [7:0]  sd_dout;
    logic        sel;

    logic        rd_a, we_a, busy_a, done_a, error_a, hok_a;
    logic [31:0] addr_a;
    logic [18:0] maddr_a;
    logic [7:0]  wdata_a;
    logic [19:0] bl_a;
    logic        rd_b, we_b, busy_b, done_b, error_b, hok_b;
    logic [31:0] addr_b;
    logic [8:0]  maddr_b;
    logic [7:0]  wdata_b;
    logic [9:0]  bl_b;

    logic        start_a, start_b;
    logic        sd_rd_m, mem_we_m, busy_m, done_m, error_m, header_ok_m;
    logic [31:0] sd_address_m;
    logic [19:0] mem_addr_m, bytes_loaded_m;
    logic [7:0]  mem_wdata_m;

    assign start_a        = start & ~sel;
    assign start_b        = start & sel;
    assign sd_rd_m        = sel ? rd_b : rd_a;
    assign sd_address_m   = sel ? addr_b : addr_a;
    assign mem_we_m       = sel ? we_b : we_a;
    assign mem_addr_m     = sel ? {11'b0, maddr_b} : {1'b0, maddr_a};
    assign mem_wdata_m    = sel ? wdata_b : wdata_a;
    assign busy_m         = sel ? busy_b : busy_a;
    assign done_m         = sel ? done_b : done_a;
    assign error_m        = sel ? error_b : error_a;
    assign header_ok_m    = sel ? hok_b : hok_a;
    assign bytes_loaded_m = sel ? {10'b0, bl_b} : bl_a;

    sd_rom_loader #(.MEM_AW(19), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk_25mhz(clk_25mhz), .rst(rst), .start(start_a), .base_addr(base_addr),
        .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_byte_available(sd_byte_available),
        .sd_dout(sd_dout), .sd_rd(rd_a), .sd_address(addr_a), .mem_we(we_a), .mem_addr(maddr_a),
        .mem_wdata(wdata_a), .busy(busy_a), .done(done_a), .error(error_a), .header_ok(hok_a),
        .bytes_loaded(bl_a)
    );

    sd_rom_loader #(.MEM_AW(9), .TIMEOUT_CYC(TO_CYC)) dut_small (
        .clk_25mhz(clk_25mhz), .rst(rst), .start(start_b), .base_addr(base_addr),
        .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_byte_available(sd_byte_available),
        .sd_dout(sd_dout), .sd_rd(rd_b), .sd_address(addr_b), .mem_we(we_b), .mem_addr(maddr_b),
        .mem_wdata(wdata_b), .busy(busy_b), .done(done_b), .error(error_b), .header_ok(hok_b),
        .bytes_loaded(bl_b)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    logic [7:0] hdr [4];
    logic       hdr_en      = 1'b0;
    int         model_bytes = 0;
    int         stall_at    = -1;
    int         cap         = 1 << 19;
    logic       abort_model = 1'b0;
    logic       model_active = 1'b0;
    logic [31:0] addr_log [$];
    sb_item_t   sb_q [$];

    function automatic logic [7:0] data_for(input int idx);
        if (hdr_en && idx < 4) return hdr[idx[1:0]];
        return idx[7:0];
    endfunction

    // Controller model: accepts sd_rd, drops ready, then strobes one sector of bytes.
    initial begin : ctrl_model
        sb_item_t it;
        sd_ready = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout = 8'h00;
        forever begin
            @(negedge clk_25mhz);
            if (sd_rd_m && !rst && !abort_model) begin
                model_active = 1'b1;
                addr_log.push_back(sd_address_m);
                @(negedge clk_25mhz);
                sd_ready = 1'b0;
                repeat (2) @(negedge clk_25mhz);
                for (int i = 0; i < SB; i++) begin
                    while (model_bytes == stall_at && !abort_model) @(negedge clk_25mhz);
                    if (abort_model) break;
                    sd_dout = data_for(model_bytes);
                    sd_byte_available = 1'b1;
                    if (model_bytes < cap) begin
                        it.addr = 20'(model_bytes);
                        it.data = sd_dout;
                        sb_q.push_back(it);
                    end
                    model_bytes++;
                    repeat (2) @(negedge clk_25mhz);
                    sd_byte_available = 1'b0;
                    repeat (2) @(negedge clk_25mhz);
                end
                sd_byte_available = 1'b0;
                sd_ready = 1'b1;
                model_active = 1'b0;
            end
        end
    end

    int       cycle = 0, write_count = 0, done_count = 0, rd_count = 0, rd_hold_viol = 0;
    int       t_byte100 = 0, t_err = 0;
    logic     rd_prev = 1'b0, err_prev = 1'b0, hdr_at_4 = 1'b0;
    sb_item_t mon_item;

    always @(posedge clk_25mhz) begin
        #1;
        cycle++;
        if (mem_we_m) begin
            write_count++;
            checkOutput("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_item = sb_q.pop_front();
                checkOutput("mem_addr", 32'(mem_addr_m), 32'(mon_item.addr));
                checkOutput("mem_wdata", 32'(mem_wdata_m), 32'(mon_item.data));
            end
            if (write_count == 4) hdr_at_4 = header_ok_m;
            if (write_count == 100) t_byte100 = cycle;
        end
        if (done_m) done_count++;
        if (sd_rd_m && !rd_prev) rd_count++;
        if (sd_rd_m && !sd_ready) rd_hold_viol++;
        if (error_m && !err_prev) t_err = cycle;
        rd_prev = sd_rd_m;
        err_prev = error_m;
    end

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] nsec);
        write_count = 0; done_count = 0; rd_count = 0; rd_hold_viol = 0;
        hdr_at_4 = 1'b0; t_byte100 = 0; t_err = 0;
        model_bytes = 0;
        addr_log.delete();
        sb_q.delete();
        @(negedge clk_25mhz);
        base_addr = base;
        num_sectors = nsec;
        start = 1'b1;
        @(negedge clk_25mhz);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int max_cycles);
        int n = 0;
        while (busy_m && n < max_cycles) begin
            @(negedge clk_25mhz);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy_m), 32'd0);
    endtask

    task automatic waitModel(input string tag);
        int n = 0;
        while (model_active && n < 4000) begin
            @(negedge clk_25mhz);
            n++;
        end
        checkOutput({tag, "_model_idle"}, 32'(model_active), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sd_rd"}, 32'(sd_rd_m), 32'd0);
        checkOutput({tag, "_sd_address"}, sd_address_m, 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we_m), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr_m), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata_m), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_m), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_m), 32'd0);
        checkOutput({tag, "_error"}, 32'(error_m), 32'd0);
        checkOutput({tag, "_header_ok"}, 32'(header_ok_m), 32'd0);
        checkOutput({tag, "_bytes_loaded"}, 32'(bytes_loaded_m), 32'd0);
    endtask

    initial begin : watchdog
        #(40 * 90000);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        int snap;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_sectors = '0; sel = 1'b0;
        hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
        repeat (3) @(negedge clk_25mhz);
        checkResetOutputs("por");
        rst = 1'b0;

        $display("[TB] single sector from address 0");
        applyStimulus(32'h0, 16'd1);
        waitIdle("t1", 4000);
        waitModel("t1");
        checkOutput("t1_writes", 32'(write_count), 32'd512);
        checkOutput("t1_done_count", 32'(done_count), 32'd1);
        checkOutput("t1_bytes_loaded", 32'(bytes_loaded_m), 32'd512);
        checkOutput("t1_rd_count", 32'(rd_count), 32'd1);
        checkOutput("t1_addr_log_size", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0) checkOutput("t1_sd_address", addr_log[0], 32'h0);
        checkOutput("t1_sb_left", 32'(sb_q.size()), 32'd0);
        checkOutput("t1_header_ok", 32'(header_ok_m), 32'd0);
        checkOutput("t1_error", 32'(error_m), 32'd0);

        $display("[TB] three sectors from 0x400");
        applyStimulus(32'h400, 16'd3);
        waitIdle("t2", 10000);
        waitModel("t2");
        checkOutput("t2_addr_log_size", 32'(addr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < addr_log.size())
                checkOutput($sformatf("t2_sd_address%0d", i), addr_log[i], 32'h400 + 32'(i) * 32'h200);
        checkOutput("t2_bytes_loaded", 32'(bytes_loaded_m), 32'd1536);
        checkOutput("t2_rd_count", 32'(rd_count), 32'd3);
        checkOutput("t2_rd_hold", 32'(rd_hold_viol), 32'd0);
        checkOutput("t2_done_count", 32'(done_count), 32'd1);
        checkOutput("t2_sb_left", 32'(sb_q.size()), 32'd0);

        $display("[TB] header checks");
        hdr_en = 1'b1;
        applyStimulus(32'h0, 16'd1);
        waitIdle("t3", 4000);
        waitModel("t3");
        checkOutput("t3_hdr_at_4", 32'(hdr_at_4), 32'd1);
        checkOutput("t3_header_ok", 32'(header_ok_m), 32'd1);
        checkOutput("t3_done_count", 32'(done_count), 32'd1);
        hdr[3] = 8'h00;
        applyStimulus(32'h0, 16'd1);
        waitIdle("t4", 4000);
        waitModel("t4");
        checkOutput("t4_hdr_at_4", 32'(hdr_at_4), 32'd0);
        checkOutput("t4_header_ok", 32'(header_ok_m), 32'd0);
        checkOutput("t4_done_count", 32'(done_count), 32'd1);
        checkOutput("t4_writes", 32'(write_count), 32'd512);
        hdr_en = 1'b0;

        $display("[TB] controller stall after byte 100");
        stall_at = 100;
        applyStimulus(32'h0, 16'd1);
        n = 0;
        while (!error_m && n < 3000) begin
            @(negedge clk_25mhz);
            n++;
        end
        checkOutput("t5_error", 32'(error_m), 32'd1);
        checkOutput("t5_err_delay_window",
                    32'((t_err - t_byte100) >= 1000 && (t_err - t_byte100) <= 1002), 32'd1);
        @(negedge clk_25mhz);
        checkOutput("t5_busy_after", 32'(busy_m), 32'd0);
        checkOutput("t5_done_count", 32'(done_count), 32'd0);
        checkOutput("t5_writes", 32'(write_count), 32'd100);
        abort_model = 1'b1;
        waitModel("t5");
        abort_model = 1'b0;
        stall_at = -1;
        applyStimulus(32'h0, 16'd0);
        checkOutput("t5_error_cleared", 32'(error_m), 32'd0);
        waitIdle("t5b", 10);
        checkOutput("t5_restart_done", 32'(done_count), 32'd1);

        $display("[TB] overflow with a 512-byte memory");
        sel = 1'b1;
        cap = 512;
        applyStimulus(32'h0, 16'd2);
        n = 0;
        while (!error_m && n < 6000) begin
            @(negedge clk_25mhz);
            n++;
        end
        checkOutput("t6_error", 32'(error_m), 32'd1);
        checkOutput("t6_writes", 32'(write_count), 32'd512);
        checkOutput("t6_done_count", 32'(done_count), 32'd0);
        checkOutput("t6_bytes_loaded", 32'(bytes_loaded_m), 32'd512);
        waitModel("t6");
        checkOutput("t6_writes_after", 32'(write_count), 32'd512);
        checkOutput("t6_sb_left", 32'(sb_q.size()), 32'd0);
        sel = 1'b0;
        cap = 1 << 19;

        $display("[TB] reset in the middle of a load");
        applyStimulus(32'h0, 16'd1);
        n = 0;
        while (model_bytes < 50 && n < 1000) begin
            @(negedge clk_25mhz);
            n++;
        end
        checkOutput("t7_reached_byte50", 32'(model_bytes >= 50), 32'd1);
        rst = 1'b1;
        abort_model = 1'b1;
        @(posedge clk_25mhz);
        #1;
        checkResetOutputs("t7");
        snap = write_count;
        @(negedge clk_25mhz);
        rst = 1'b0;
        repeat (80) @(negedge clk_25mhz);
        checkOutput("t7_no_write", 32'(write_count), 32'(snap));
        checkOutput("t7_busy", 32'(busy_m), 32'd0);
        waitModel("t7");
        abort_model = 1'b0;
        sb_q.delete();

        $display("[TB] zero-sector load");
        applyStimulus(32'h0, 16'd0);
        waitIdle("t8", 10);
        repeat (2) @(negedge clk_25mhz);
        checkOutput("t8_done_count", 32'(done_count), 32'd1);
        checkOutput("t8_rd_count", 32'(rd_count), 32'd0);
        checkOutput("t8_error", 32'(error_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
